tsum_averager: RTL and testbench
================================

TSUM_AVERAGER -- requirements
Module: tsum_averager

Interface
REQ-001 Parameter TSUM_W, default 16: width of the running-sum input and the quotient datapath.
REQ-002 Parameter N_W, default 4: width of the sample-count input.
REQ-003 Parameter TAVG_W, default 12: width of the averaged-period output.
REQ-004 Port CLK  input  1: clock; all state updates on its rising edge.
REQ-005 Port RESET  input  1: reset, synchronous, active-high.
REQ-006 Port START  input  1: request to divide the current TSUM by the current N.
REQ-007 Port TSUM  input  TSUM_W: running sum of stored period samples.
REQ-008 Port N  input  N_W: number of valid samples in TSUM.
REQ-009 Port TAVG  output  TAVG_W: registered result, TSUM/N, held until the next completion.
REQ-010 Port DONE  output  1: one-cycle pulse; TAVG, DZ and OVF are updated in the same cycle.
REQ-011 Port BUSY  output  1: high whenever the state is not IDLE.
REQ-012 Port DZ  output  1: divide-by-zero flag for the last result.
REQ-013 Port OVF  output  1: quotient-exceeded-TAVG_W flag for the last result.

Function
REQ-014 The state machine SHALL have states IDLE, DIV and FIN; IDLE->DIV on START, DIV->FIN after TSUM_W iterations, FIN->IDLE unconditionally.
REQ-015 A START sampled high in IDLE at edge k SHALL latch TSUM and N into internal registers and enter DIV; START in DIV or FIN SHALL be ignored, with no effect on the latched operands.
REQ-016 DIV SHALL perform one restoring shift-subtract step per cycle, MSB first, at edges k+1 .. k+16 (for TSUM_W=16), producing a TSUM_W-bit quotient and an N_W-bit remainder.
REQ-017 At edge k+17 (FIN->IDLE), TAVG, DZ and OVF SHALL be registered and DONE SHALL be high for exactly that one cycle; latency is fixed at 17 cycles for every operand value.
REQ-018 A new START SHALL be accepted at edge k+18 at the earliest; back-to-back throughput is one result per 18 cycles.
REQ-019 If the latched N==0: TAVG=0, DZ=1, OVF=0, with the same fixed latency.
REQ-020 If N!=0 and the final quotient exceeds 2^TAVG_W-1: TAVG saturates to all-ones, OVF=1, DZ=0.
REQ-021 Otherwise: TAVG is the quotient's low TAVG_W bits, DZ=0, OVF=0.
REQ-022 DZ and OVF SHALL hold their values until the next DONE.

Reset
REQ-023 RESET high at any edge SHALL force state IDLE and clear TAVG, DONE, DZ, OVF and all internal registers to 0, regardless of state; BUSY is therefore 0.
REQ-024 A division aborted by RESET SHALL produce no DONE pulse.
REQ-025 RESET SHALL take priority over START in the same cycle.

Configuration
REQ-026 Macro TSUM_AVG_ROUND_EN defined: when N!=0 and 2*remainder >= N, the quotient SHALL be incremented before the saturation check, giving round-half-up.
REQ-027 TSUM_AVG_ROUND_EN undefined: the quotient SHALL be truncated; no rounding logic is compiled in.

Structure
REQ-028 The shared package tsum_avg_pkg SHALL hold the state enum (IDLE/DIV/FIN), the default width constants TSUM_W/N_W/TAVG_W and the iteration count DIV_ITERS = TSUM_W.
REQ-029 One combinational sub-module, tsum_div_step, SHALL implement a single restoring step (remainder in, next bit in, divisor in -> remainder out, quotient bit out); it is instantiated once in the top.

Verification
REQ-030 TSUM=14000, N=14, START pulse -> BUSY high for 17 cycles; DONE at edge k+17; TAVG=1000; DZ=0; OVF=0.
REQ-031 TSUM=20, N=3 -> TAVG=6 without TSUM_AVG_ROUND_EN; TAVG=7 with it. TSUM=19, N=3 -> TAVG=6 in both builds.
REQ-032 TSUM=500, N=0 -> DONE at k+17; TAVG=0; DZ=1; OVF=0.
REQ-033 TSUM=65535, N=1 -> TAVG=4095; OVF=1; DZ=0.
REQ-034 START with TSUM=1200, N=12, then START held high with TSUM=9999, N=3 for cycles k+1..k+17 -> single DONE with TAVG=100; the next result is accepted only at k+18.
REQ-035 RESET asserted at edge k+8 during DIV -> BUSY=0 and TAVG=0 from that edge; no DONE pulse appears in the following 20 cycles.

Source files
------------

// File: rtl/tsum_avg_pkg.sv
// tsum_avg_pkg -- shared definitions for the period averager.
//   - default datapath widths (TSUM_W, N_W, TAVG_W)
//   - DIV_ITERS: one restoring step per dividend bit
//   - state_e: controller states IDLE / DIV / FIN
package tsum_avg_pkg;

    localparam int TSUM_W    = 16;
    localparam int N_W       = 4;
    localparam int TAVG_W    = 12;
    localparam int DIV_ITERS = TSUM_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/tsum_div_step.sv
// tsum_div_step -- one combinational restoring-division step.
//   rem_i : partial remainder from the previous step (N_W bits)
//   bit_i : next dividend bit, MSB first
//   div_i : divisor
//   rem_o : partial remainder after this step
//   q_o   : quotient bit produced by this step
module tsum_div_step #(
    parameter int N_W = tsum_avg_pkg::N_W
) (
    input  logic [N_W-1:0] rem_i,
    input  logic           bit_i,
    input  logic [N_W-1:0] div_i,
    output logic [N_W-1:0] rem_o,
    output logic           q_o
);

    logic [N_W:0] trial;
    logic [N_W:0] diff;

    // Partial remainder is always < divisor, so the shifted trial value
    // is < 2*divisor and the difference always fits back into N_W bits.
    assign trial = {rem_i, bit_i};
    assign diff  = trial - {1'b0, div_i};
    assign q_o   = (trial >= {1'b0, div_i});
    assign rem_o = q_o ? diff[N_W-1:0] : trial[N_W-1:0];

endmodule

// File: rtl/tsum_averager.sv
// tsum_averager -- sequential TSUM/N divider producing an averaged period.
//   CLK, RESET : clock, synchronous active-high reset
//   START      : request a division of TSUM by N (accepted only in IDLE)
//   TSUM, N    : dividend (running sum) and divisor (sample count)
//   TAVG       : registered quotient, saturated to TAVG_W bits
//   DONE       : one-cycle pulse when TAVG/DZ/OVF update
//   BUSY       : high while a division is in flight
//   DZ, OVF    : divide-by-zero / saturation flags for the last result
// Optional build macro TSUM_AVG_ROUND_EN: round half up instead of truncating.
// Latency is fixed: START at edge k -> DONE registered at edge k+TSUM_W+1.
module tsum_averager #(
    parameter int TSUM_W = tsum_avg_pkg::TSUM_W,
    parameter int N_W    = tsum_avg_pkg::N_W,
    parameter int TAVG_W = tsum_avg_pkg::TAVG_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [TSUM_W-1:0] TSUM,
    input  logic [N_W-1:0]    N,
    output logic [TAVG_W-1:0] TAVG,
    output logic              DONE,
    output logic              BUSY,
    output logic              DZ,
    output logic              OVF
);

    import tsum_avg_pkg::*;

    localparam int ITERS = TSUM_W;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    state_e state_q, state_d;

    // dq_q starts as the dividend and shifts left each step while quotient
    // bits enter at the bottom; after ITERS steps it holds the quotient.
    logic [TSUM_W-1:0] dq_q,   dq_d;
    logic [N_W-1:0]    rem_q,  rem_d;
    logic [N_W-1:0]    div_q,  div_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic [TAVG_W-1:0] tavg_q, tavg_d;
    logic              dz_q,   dz_d;
    logic              ovf_q,  ovf_d;
    logic              done_q, done_d;

    logic [N_W-1:0]    step_rem;
    logic              step_bit;
    logic [TSUM_W:0]   q_fin;
    logic              q_sat;

    tsum_div_step #(.N_W(N_W)) u_step (
        .rem_i (rem_q),
        .bit_i (dq_q[TSUM_W-1]),
        .div_i (div_q),
        .rem_o (step_rem),
        .q_o   (step_bit)
    );

`ifdef TSUM_AVG_ROUND_EN
    logic rnd_up;
    // Round half up: remainder/N >= 1/2  <=>  2*remainder >= N.
    assign rnd_up = (div_q != '0) && ({rem_q, 1'b0} >= {1'b0, div_q});
    assign q_fin  = {1'b0, dq_q} + {{TSUM_W{1'b0}}, rnd_up};
`else
    assign q_fin  = {1'b0, dq_q};
`endif

    // Extra top bit catches a rounding carry out of the full quotient.
    assign q_sat = |q_fin[TSUM_W:TAVG_W];

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (START) state_d = DIV;
            DIV:     if (cnt_q == LAST_ITER) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        dq_d   = dq_q;
        rem_d  = rem_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        tavg_d = tavg_q;
        dz_d   = dz_q;
        ovf_d  = ovf_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    dq_d  = TSUM;
                    div_d = N;
                    rem_d = '0;
                    cnt_d = '0;
                end
            end
            DIV: begin
                dq_d  = {dq_q[TSUM_W-2:0], step_bit};
                rem_d = step_rem;
                cnt_d = cnt_q + 1'b1;
            end
            FIN: begin
                done_d = 1'b1;
                if (div_q == '0) begin
                    tavg_d = '0;
                    dz_d   = 1'b1;
                    ovf_d  = 1'b0;
                end else if (q_sat) begin
                    tavg_d = '1;
                    dz_d   = 1'b0;
                    ovf_d  = 1'b1;
                end else begin
                    tavg_d = q_fin[TAVG_W-1:0];
                    dz_d   = 1'b0;
                    ovf_d  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            dq_q   <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            tavg_q <= '0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            dq_q   <= dq_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tavg_q <= tavg_d;
            dz_q   <= dz_d;
            ovf_q  <= ovf_d;
            done_q <= done_d;
        end
    end

    assign TAVG = tavg_q;
    assign DONE = done_q;
    assign DZ   = dz_q;
    assign OVF  = ovf_q;
    assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_tsum_averager.sv
module tb_tsum_averager;

    logic        CLK = 1'b0;
    logic        RESET, START;
    logic [15:0] TSUM;
    logic [3:0]  N;
    logic [11:0] TAVG;
    logic        DONE, BUSY, DZ, OVF;

    typedef struct packed {
        logic [11:0] tavg;
        logic        dz;
        logic        ovf;
    } res_t;

    res_t sb[$];
    res_t last;
    int   vecs = 0;
    int   errs = 0;

    tsum_averager dut (
        .CLK   (CLK),
        .RESET (RESET),
        .START (START),
        .TSUM  (TSUM),
        .N     (N),
        .TAVG  (TAVG),
        .DONE  (DONE),
        .BUSY  (BUSY),
        .DZ    (DZ),
        .OVF   (OVF)
    );

    always #5 CLK = ~CLK;

    function automatic res_t model(input int t, input int n);
        res_t r;
        int   q, rm;
        r = '0;
        if (n == 0) begin
            r.dz = 1'b1;
            return r;
        end
        q  = t / n;
        rm = t % n;
`ifdef TSUM_AVG_ROUND_EN
        if (2 * rm >= n) q = q + 1;
`endif
        if (q > 4095) begin
            r.tavg = 12'hFFF;
            r.ovf  = 1'b1;
        end else begin
            r.tavg = q[11:0];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present operands at the falling edge; returns #1 after edge k.
    task automatic drive(input int t, input int n, input bit push);
        @(negedge CLK);
        START = 1'b1;
        TSUM  = t[15:0];
        N     = n[3:0];
        if (push) sb.push_back(model(t, n));
        @(posedge CLK);
        #1;
    endtask

    // Called #1 after edge k; waits (bounded) for DONE and checks result.
    task automatic wait_result(input string tag);
        int   lat;
        int   busy;
        res_t e;
        lat  = 0;
        busy = 0;
        chk({tag, " held"}, 32'({TAVG, DZ, OVF}), 32'(last));
        if (BUSY) busy = 1;
        for (int i = 1; i <= 25; i++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
                lat = i;
                break;
            end
            if (BUSY) busy++;
        end
        chk({tag, " latency"}, lat, 17);
        chk({tag, " busy"}, busy, 17);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk({tag, " tavg"}, 32'(TAVG), 32'(e.tavg));
        chk({tag, " dz"},   32'(DZ),   32'(e.dz));
        chk({tag, " ovf"},  32'(OVF),  32'(e.ovf));
        last = e;
        @(posedge CLK);
        #1;
        chk({tag, " done_pulse"}, 32'(DONE), 0);
    endtask

    task automatic run_op(input int t, input int n, input string tag);
        drive(t, n, 1'b1);
        START = 1'b0;
        wait_result(tag);
    endtask

    initial begin
        int dones;
        int rt, rn;
        RESET = 1'b1;
        START = 1'b0;
        TSUM  = '0;
        N     = '0;
        last  = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst tavg", 32'(TAVG), 0);
        chk("rst done", 32'(DONE), 0);
        chk("rst busy", 32'(BUSY), 0);
        chk("rst dz",   32'(DZ),   0);
        chk("rst ovf",  32'(OVF),  0);
        @(negedge CLK);
        RESET = 1'b0;

        run_op(14000, 14, "avg1000");
        run_op(20, 3,     "round20_3");
        run_op(19, 3,     "round19_3");
        run_op(500, 0,    "divzero");
        run_op(4095, 1,   "max_fit");
        run_op(4096, 1,   "min_ovf");
        run_op(65535, 15, "ovf_15");
        run_op(0, 5,      "zero_num");

        // START held through DIV/FIN must not disturb the in-flight operands;
        // it is picked up at k+18.
        drive(1200, 12, 1'b1);
        TSUM = 16'd9999;
        N    = 4'd3;
        sb.push_back(model(9999, 3));
        wait_result("hold_first");
        chk("hold accept", 32'(BUSY), 1);
        START = 1'b0;
        wait_result("hold_second");

        run_op(65535, 1, "sat_full");

        // Abort at k+8.
        drive(1200, 12, 1'b0);
        START = 1'b0;
        repeat (7) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("abort busy", 32'(BUSY), 0);
        chk("abort tavg", 32'(TAVG), 0);
        chk("abort ovf",  32'(OVF),  0);
        chk("abort done", 32'(DONE), 0);
        last = '0;
        @(negedge CLK);
        RESET = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            if (DONE) dones++;
        end
        chk("abort no_done", dones, 0);

        // Reset wins over a simultaneous START.
        @(negedge CLK);
        RESET = 1'b1;
        START = 1'b1;
        TSUM  = 16'd100;
        N     = 4'd5;
        @(posedge CLK);
        #1;
        chk("rst_prio busy", 32'(BUSY), 0);
        @(negedge CLK);
        RESET = 1'b0;
        START = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_prio idle", 32'(BUSY), 0);

        for (int j = 0; j < 4; j++) begin
            rt = int'($urandom_range(0, 65535));
            rn = int'($urandom_range(0, 15));
            run_op(rt, rn, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
